aes_stream_loader: RTL and testbench

Byte-serial front end for the AES cipher cores. It accepts a key, whose length is set by modeSelector, and a 128-bit plaintext block over a valid/ready byte stream, and assembles them big-endian. It then issues a one-cycle start to the selected cipher core and waits for done. Finally it streams the 16 result bytes back out over a valid/ready interface. It replaces the hard-wired key and plaintext constants as the input side of the AES datapath.

---
 rtl/aes_stream_loader.sv | 188 ++++++++++++++++++
 tb/tb_aes_stream_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_loader.sv
// aes_stream_loader: byte-serial front end for the AES cipher cores.
// Collects a key (16/24/32 bytes, chosen by modeSelector on the first byte of
// a frame) and a 16-byte plaintext block, both big-endian. It then pulses
// start for one cycle, waits for done, and streams the 16 result bytes back
// out MSB-first.
//
// Handshake: a byte moves on a rising clk edge when valid && ready are both
// high. A producer holding valid keeps its data stable until it sees ready.
// Here out_valid/out_data hold steady while out_ready is low, and in_ready
// never depends on in_valid.
module aes_stream_loader #(
  parameter int KEY_W = 256,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       modeSelector,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [KEY_W-1:0] keyOut,
  output logic [1:0]       modeOut,
  output logic [127:0]     textOut,
  output logic             start,
  input  logic             done,
  input  logic [127:0]     resultIn,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             errorFlag,
  output logic [CNT_W-1:0] blocksDone
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_KEY  = 3'd1,
    S_LOAD_TEXT = 3'd2,
    S_START     = 3'd3,
    S_WAIT      = 3'd4,
    S_SEND      = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [5:0]         r_cnt;
  logic [KEY_W-1:0]   r_key;
  logic [1:0]         r_mode;
  logic [127:0]       r_text;
  logic [127:0]       r_sr;
  logic               r_err;
  logic [CNT_W-1:0]   r_blocks;

  logic               w_in_ready;
  logic               w_start;
  logic               w_out_valid;
  logic               w_in_fire;
  logic               w_out_fire;
  logic [5:0]         w_key_last;

  // Index of the last key byte for the latched mode (K-1).
  always_comb begin
    case (r_mode)
      2'b01:   w_key_last = 6'd23;
      2'b10:   w_key_last = 6'd31;
      default: w_key_last = 6'd15;
    endcase
  end

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and handshake/strobe decode.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_start      = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid && modeSelector != 2'b11) w_next_state = S_LOAD_KEY;
      end
      S_LOAD_KEY: begin
        w_in_ready = 1'b1;
        if (in_valid && r_cnt == w_key_last) w_next_state = S_LOAD_TEXT;
      end
      S_LOAD_TEXT: begin
        w_in_ready = 1'b1;
        if (in_valid && r_cnt == 6'd15) w_next_state = S_START;
      end
      S_START: begin
        w_start      = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (done) w_next_state = S_SEND;
      end
      S_SEND: begin
        w_out_valid = 1'b1;
        if (out_ready && r_cnt == 6'd15) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_in_fire  = in_valid & w_in_ready;
  assign w_out_fire = w_out_valid & out_ready;

  // Datapath: byte counter, key/text assembly, result shifter, status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_key    <= '0;
      r_mode   <= 2'b00;
      r_text   <= '0;
      r_sr     <= '0;
      r_err    <= 1'b0;
      r_blocks <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_fire) begin
            if (modeSelector == 2'b11) begin
              r_err <= 1'b1;
            end else begin
              r_mode <= modeSelector;
              r_key  <= {in_data, {(KEY_W-8){1'b0}}};
              r_cnt  <= 6'd1;
            end
          end
        end
        S_LOAD_KEY: begin
          if (w_in_fire) begin
            for (int b = 1; b < KEY_W/8; b++) begin
              if (r_cnt == 6'(b)) r_key[KEY_W-1-8*b -: 8] <= in_data;
            end
            if (r_cnt == w_key_last) r_cnt <= '0;
            else                     r_cnt <= r_cnt + 6'd1;
          end
        end
        S_LOAD_TEXT: begin
          if (w_in_fire) begin
            for (int b = 0; b < 16; b++) begin
              if (r_cnt == 6'(b)) r_text[127-8*b -: 8] <= in_data;
            end
            if (r_cnt == 6'd15) r_cnt <= '0;
            else                r_cnt <= r_cnt + 6'd1;
          end
        end
        S_WAIT: begin
          if (done) begin
            r_sr  <= resultIn;
            r_cnt <= '0;
          end
        end
        S_SEND: begin
          if (w_out_fire) begin
            r_sr <= {r_sr[119:0], 8'h00};
            if (r_cnt == 6'd15) begin
              r_cnt    <= '0;
              r_blocks <= r_blocks + 1'b1;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // in_ready is held low while reset is asserted.
  assign in_ready   = w_in_ready & ~reset;
  assign start      = w_start;
  assign out_valid  = w_out_valid;
  assign out_data   = r_sr[127:120];
  assign keyOut     = r_key;
  assign modeOut    = r_mode;
  assign textOut    = r_text;
  assign busy       = (r_state != S_IDLE);
  assign errorFlag  = r_err;
  assign blocksDone = r_blocks;

endmodule

// File: tb/tb_aes_stream_loader.sv
// Testbench for aes_stream_loader: table of frames with hand-computed expected
// key/text/result values, plus sequences for illegal mode, backpressure and
// reset during SEND.
module tb_aes_stream_loader;

  localparam int KEY_W = 256;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       modeSelector;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic [KEY_W-1:0] keyOut;
  logic [1:0]       modeOut;
  logic [127:0]     textOut;
  logic             start;
  logic             done;
  logic [127:0]     resultIn;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_ready;
  logic             busy;
  logic             errorFlag;
  logic [CNT_W-1:0] blocksDone;

  aes_stream_loader #(.KEY_W(KEY_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .modeSelector(modeSelector),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .keyOut(keyOut), .modeOut(modeOut), .textOut(textOut),
    .start(start), .done(done), .resultIn(resultIn),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .errorFlag(errorFlag), .blocksDone(blocksDone)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   mode;
    int           klen;
    logic [255:0] exp_key;
    logic [127:0] text;
    logic [127:0] res;
    bit           toggle;
    bit           stall;
    bit           hold;
    int           abort_at;
  } vec_t;

  vec_t       vecs[6];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         exp_blocks = 0;
  logic       exp_err = 1'b0;
  int         start_cnt = 0;

  // Count cycles with start high (sampled mid-cycle).
  always @(negedge clk) if (start === 1'b1) start_cnt++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte until accepted (bounded).
  task automatic send_byte(input logic [7:0] b);
    int tries = 0;
    bit got = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!got && tries < 50) begin
      @(negedge clk);
      got = in_ready;
      tries++;
      tick();
    end
    if (!got) check("in_ready_timeout", 256'(got), 256'd1);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int vi);
    vec_t       v;
    int         n;
    int         cyc;
    int         s0;
    bit         stall_prev;
    logic [7:0] prev_d;
    logic [7:0] exp_b;
    v  = vecs[vi];
    s0 = start_cnt;
    modeSelector = v.mode;
    for (int i = 0; i < v.klen; i++) begin
      send_byte(v.exp_key[255-8*i -: 8]);
      if (v.toggle && i == 3) modeSelector = 2'b00;
    end
    for (int i = 0; i < 16; i++) send_byte(v.text[127-8*i -: 8]);
    // START cycle
    @(negedge clk);
    check("start_after_text", 256'(start), 256'd1);
    check("in_ready_start", 256'(in_ready), 256'd0);
    check("busy_start", 256'(busy), 256'd1);
    check("keyOut", keyOut, v.exp_key);
    check("modeOut", 256'(modeOut), 256'(v.mode));
    check("textOut", 256'(textOut), 256'(v.text));
    tick();
    repeat (3) tick();
    check("start_pulses", 256'(start_cnt - s0), 256'd1);
    done     = 1'b1;
    resultIn = v.res;
    for (int i = 0; i < 16; i++) exp_q.push_back(v.res[127-8*i -: 8]);
    @(negedge clk);
    check("ovalid_before_done", 256'(out_valid), 256'd0);
    tick();
    if (!v.hold) done = 1'b0;
    n = 0;
    cyc = 0;
    stall_prev = 0;
    prev_d = 8'h00;
    while (n < 16 && cyc < 300) begin
      out_ready = v.stall ? ($urandom_range(0, 9) < 3) : 1'b1;
      @(negedge clk);
      check("out_valid_send", 256'(out_valid), 256'd1);
      check("in_ready_send", 256'(in_ready), 256'd0);
      if (stall_prev) check("stall_hold", 256'(out_data), 256'(prev_d));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("exp_q_empty", 256'd1, 256'd0);
        end else begin
          exp_b = exp_q.pop_front();
          check("out_byte", 256'(out_data), 256'(exp_b));
        end
        n++;
        stall_prev = 0;
      end else begin
        stall_prev = out_valid;
        prev_d     = out_data;
      end
      cyc++;
      tick();
      if (v.abort_at != 0 && n == v.abort_at) begin
        reset = 1'b1;
        #1;
        check("abort_out_valid", 256'(out_valid), 256'd0);
        @(negedge clk);
        check("abort_blocks", 256'(blocksDone), 256'd0);
        check("abort_err", 256'(errorFlag), 256'd0);
        check("abort_key", keyOut, 256'd0);
        check("abort_busy", 256'(busy), 256'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b0;
        done = 1'b0;
        exp_q.delete();
        exp_blocks = 0;
        exp_err = 1'b0;
        s0 = start_cnt;
        n = 0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (out_valid) n++;
          tick();
        end
        check("abort_no_out_valid", 256'(n), 256'd0);
        check("abort_no_start", 256'(start_cnt - s0), 256'd0);
        return;
      end
    end
    if (n < 16) check("send_timeout", 256'(n), 256'd16);
    out_ready = 1'b0;
    done = 1'b0;
    exp_blocks++;
    @(negedge clk);
    check("out_valid_after", 256'(out_valid), 256'd0);
    check("busy_after", 256'(busy), 256'd0);
    check("in_ready_after", 256'(in_ready), 256'd1);
    check("blocksDone", 256'(blocksDone), 256'(exp_blocks));
    check("errorFlag", 256'(errorFlag), 256'(exp_err));
    check("start_total", 256'(start_cnt - s0), 256'd1);
    tick();
  endtask

  initial begin
    vecs[0] = '{mode: 2'b00, klen: 16,
      exp_key: 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000,
      text: 128'h00112233445566778899aabbccddeeff,
      res: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
      toggle: 0, stall: 0, hold: 0, abort_at: 0};
    vecs[1] = '{mode: 2'b01, klen: 24,
      exp_key: 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000,
      text: 128'h00112233445566778899aabbccddeeff,
      res: 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
      toggle: 0, stall: 0, hold: 0, abort_at: 0};
    vecs[2] = '{mode: 2'b10, klen: 32,
      exp_key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
      text: 128'h00112233445566778899aabbccddeeff,
      res: 128'h8ea2b7ca516745bfeafc49904b496089,
      toggle: 1, stall: 0, hold: 0, abort_at: 0};
    vecs[3] = vecs[0];
    vecs[3].stall = 1;
    vecs[3].hold  = 1;
    vecs[4] = vecs[1];
    vecs[4].abort_at = 7;
    vecs[5] = vecs[0];

    // Reset
    reset = 1'b1;
    modeSelector = 2'b00;
    in_valid = 1'b0;
    in_data = 8'h00;
    done = 1'b0;
    resultIn = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_keyOut", keyOut, 256'd0);
    check("rst_textOut", 256'(textOut), 256'd0);
    check("rst_modeOut", 256'(modeOut), 256'd0);
    check("rst_start", 256'(start), 256'd0);
    check("rst_out_valid", 256'(out_valid), 256'd0);
    check("rst_out_data", 256'(out_data), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_errorFlag", 256'(errorFlag), 256'd0);
    check("rst_blocksDone", 256'(blocksDone), 256'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 256'(in_ready), 256'd1);
    tick();

    for (int f = 0; f < 6; f++) begin
      if (f == 3) begin
        // Illegal mode on a first byte: flag set, byte dropped, stay idle.
        modeSelector = 2'b11;
        send_byte(8'haa);
        exp_err = 1'b1;
        @(negedge clk);
        check("illegal_err", 256'(errorFlag), 256'd1);
        check("illegal_busy", 256'(busy), 256'd0);
        check("illegal_mode_kept", 256'(modeOut), 256'(2'b10));
        check("illegal_key_kept", keyOut, vecs[2].exp_key);
        tick();
      end
      run_frame(f);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
